rs232_tx_nbytes: RTL and testbench

//  Multi-byte RS-232 UART transmitter: accepts an N_BYTES*N_BITS word on a start strobe and

---
 rtl/rs232_tx_nbytes.sv | 148 ++++++++++++++
 tb/tb_rs232_tx_nbytes.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_nbytes.sv
// Multi-byte RS-232 transmitter: serialises N_BYTES bytes (MSB byte first) as
// back-to-back start/data/stop frames, each bit held for BAUD_DIV clock cycles.
module rs232_tx_nbytes #(
    parameter int N_BYTES   = 8,
    parameter int N_BITS    = 8,
    parameter int MSB_FIRST = 1,
    parameter int BAUD_DIV  = 10416
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tx_start,
    input  logic [N_BYTES*N_BITS-1:0]   data_in,
    output logic                        tx_ready,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic                        rs232_txd
);

    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BYTE_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int BIT_W  = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t                      state_q;
    logic [BAUD_W-1:0]           baud_q;
    logic [BIT_W-1:0]            bit_q;
    logic [BYTE_W-1:0]           byte_q;
    logic [N_BYTES*N_BITS-1:0]   hold_q;
    logic [N_BITS-1:0]           shift_q;
    logic                        txd_q;
    logic                        ready_q;
    logic                        busy_q;
    logic                        done_q;

    logic                        baud_end_s;
    logic [N_BITS-1:0]           cur_byte_s;

    // Bit that goes on the line next, depending on transmit bit order.
    function automatic logic lead_bit(input logic [N_BITS-1:0] b);
        return (MSB_FIRST != 0) ? b[N_BITS-1] : b[0];
    endfunction

    // Remaining bits after the lead bit has been sent.
    function automatic logic [N_BITS-1:0] shift_out(input logic [N_BITS-1:0] b);
        return (MSB_FIRST != 0) ? (b << 1) : (b >> 1);
    endfunction

    assign baud_end_s = (baud_q == BAUD_W'(BAUD_DIV - 1));
    assign cur_byte_s = hold_q[byte_q*N_BITS +: N_BITS];

    // Frame sequencer; every output is a register so the line never glitches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            hold_q  <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (tx_start) begin
                        hold_q  <= data_in;
                        byte_q  <= BYTE_W'(N_BYTES - 1);
                        bit_q   <= '0;
                        txd_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end else begin
                        txd_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (baud_end_s) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        txd_q   <= lead_bit(cur_byte_s);
                        shift_q <= shift_out(cur_byte_s);
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end_s) begin
                        baud_q <= '0;
                        if (bit_q == BIT_W'(N_BITS - 1)) begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            txd_q   <= lead_bit(shift_q);
                            shift_q <= shift_out(shift_q);
                            bit_q   <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                S_STOP: begin
                    if (baud_end_s) begin
                        baud_q <= '0;
                        // Next byte's start bit follows the stop bit with no idle gap.
                        if (byte_q != BYTE_W'(0)) begin
                            byte_q  <= byte_q - BYTE_W'(1);
                            txd_q   <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            txd_q   <= 1'b1;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    baud_q  <= '0;
                    txd_q   <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rs232_txd = txd_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_rs232_tx_nbytes.sv
// Bench for rs232_tx_nbytes: two instances (MSB-first and LSB-first), 2 bytes x 8 bits,
// 4 cycles per bit, checked against hand-computed 20-bit line patterns.
module tb_rs232_tx_nbytes;

    logic        clk;
    logic        reset;
    logic        start_m, start_l;
    logic [15:0] data_m, data_l;
    logic        ready_m, busy_m, done_m, txd_m;
    logic        ready_l, busy_l, done_l, txd_l;

    int checks;
    int errors;

    rs232_tx_nbytes #(.N_BYTES(2), .N_BITS(8), .MSB_FIRST(1), .BAUD_DIV(4)) u_msb (
        .clk(clk), .reset(reset), .tx_start(start_m), .data_in(data_m),
        .tx_ready(ready_m), .tx_busy(busy_m), .tx_done(done_m), .rs232_txd(txd_m)
    );

    rs232_tx_nbytes #(.N_BYTES(2), .N_BITS(8), .MSB_FIRST(0), .BAUD_DIV(4)) u_lsb (
        .clk(clk), .reset(reset), .tx_start(start_l), .data_in(data_l),
        .tx_ready(ready_l), .tx_busy(busy_l), .tx_done(done_l), .rs232_txd(txd_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;    // 0: MSB-first instance, 1: LSB-first instance
        logic [15:0] data;
        logic [19:0] bits;   // expected line, one entry per bit time, [19] first
    } vec_t;

    vec_t vecs[5];

    // {txd, ready, busy, done} of the selected instance
    function automatic logic [3:0] st(input logic sel);
        return sel ? {txd_l, ready_l, busy_l, done_l} : {txd_m, ready_m, busy_m, done_m};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic accept(input logic sel, input logic [15:0] d);
        @(negedge clk);
        if (sel) begin start_l = 1'b1; data_l = d; end
        else     begin start_m = 1'b1; data_m = d; end
        @(posedge clk);
        #1;
        start_l = 1'b0;
        start_m = 1'b0;
        data_l  = ~d;
        data_m  = ~d;
    endtask

    // Called just after an accept edge: checks 80 cycles of line plus the tx_done cycle.
    task automatic check_set(input logic sel, input logic [19:0] bits, input string tag);
        logic [3:0] s;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            s = st(sel);
            check({tag, " line"}, {31'd0, s[3]}, {31'd0, bits[19 - (k - 1) / 4]});
            check({tag, " rdy/busy/done"}, {29'd0, s[2:0]}, 32'd2);
        end
        @(negedge clk);
        check({tag, " done cycle"}, {28'd0, st(sel)}, 32'hD);
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7 - i];
        return r;
    endfunction

    initial begin
        logic [19:0] frame;
        logic [15:0] d;
        logic [15:0] got;
        logic        sel;
        int          bad;

        checks  = 0;
        errors  = 0;
        start_m = 1'b0;
        start_l = 1'b0;
        data_m  = 16'h0000;
        data_l  = 16'h0000;
        reset   = 1'b0;

        vecs[0] = '{1'b0, 16'hA53C, 20'b0101001011_0001111001};
        vecs[1] = '{1'b1, 16'h0180, 20'b0100000001_0000000011};
        vecs[2] = '{1'b0, 16'hFFFF, 20'b0111111111_0111111111};
        vecs[3] = '{1'b1, 16'h0000, 20'b0000000001_0000000001};
        vecs[4] = '{1'b1, 16'h8001, 20'b0000000011_0100000001};

        // reset held for 5 cycles
        repeat (5) @(negedge clk);
        check("reset msb", {28'd0, st(1'b0)}, 32'hC);
        check("reset lsb", {28'd0, st(1'b1)}, 32'hC);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle msb", {28'd0, st(1'b0)}, 32'hC);

        // table-driven single transfers
        foreach (vecs[i]) begin
            accept(vecs[i].sel, vecs[i].data);
            check_set(vecs[i].sel, vecs[i].bits, $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d after", i), {28'd0, st(vecs[i].sel)}, 32'hC);
        end

        // tx_start held high: back-to-back sets, data change mid-set ignored
        @(negedge clk);
        start_m = 1'b1;
        data_m  = 16'hA53C;
        @(posedge clk);
        fork
            check_set(1'b0, 20'b0101001011_0001111001, "hold set1");
            begin
                repeat (10) @(negedge clk);
                data_m = 16'h0180;
            end
        join
        @(posedge clk);
        check_set(1'b0, 20'b0000000011_0100000001, "hold set2");
        @(posedge clk);
        #1;
        start_m = 1'b0;
        check_set(1'b0, 20'b0000000011_0100000001, "hold set3");

        // reset during second byte's data bits abandons the transfer
        accept(1'b0, 16'hA53C);
        repeat (50) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("midreset state", {28'd0, st(1'b0)}, 32'hC);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (st(1'b0) !== 4'hC) bad++;
        end
        check("midreset quiet", bad, 32'd0);
        accept(1'b0, 16'hA53C);
        check_set(1'b0, 20'b0101001011_0001111001, "post reset");

        // loopback through a bench-side receiver sampling mid-bit
        for (int n = 0; n < 100; n++) begin
            sel = n[0];
            d   = 16'($urandom);
            accept(sel, d);
            frame = '0;
            for (int k = 1; k <= 80; k++) begin
                @(negedge clk);
                if (((k - 1) % 4) == 1) frame = {frame[18:0], st(sel)[3]};
            end
            @(negedge clk);
            check("loop done", {31'd0, st(sel)[0]}, 32'd1);
            check("loop framing", {28'd0, frame[19], frame[10], frame[9], frame[0]}, 32'h5);
            if (sel) got = {rev8(frame[18:11]), rev8(frame[8:1])};
            else     got = {frame[18:11], frame[8:1]};
            check("loop word", {16'd0, got}, {16'd0, d});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
